// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (shift-add multiply, restoring divide).
// Optional macro MULDIV_EARLY_OUT_EN: trivial/special-case ops skip the iteration phase. Rev 1.0
`default_nettype none

module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [2:0]       op_in,
  input  logic [WIDTH-1:0] rs1_in,
  input  logic [WIDTH-1:0] rs2_in,
  input  logic             flush_in,
  output logic             stall_out,
  output logic             done_out,
  output logic [WIDTH-1:0] res_out
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2:0]           op_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     b_q;
  logic                 neg_q;
  logic                 rneg_q;
  logic                 spec_q;
  logic [WIDTH-1:0]     spec_res_q;
  logic                 done_q;
  logic [WIDTH-1:0]     res_q;

  logic                 a_sgn, b_sgn;
  logic [WIDTH-1:0]     mag1, mag2;
  logic                 div_zero, div_ovf, mul_zero, spec_hit;
  logic [WIDTH-1:0]     spec_res;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       shifted;
  logic                 fits;
  logic [WIDTH-1:0]     diff;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;
  logic [WIDTH-1:0]     res_d;

  // Operand decode at accept: magnitudes, signs and RISC-V special results.
  always_comb begin
    a_sgn    = (op_in inside {3'd1, 3'd2, 3'd4, 3'd6}) && rs1_in[WIDTH-1];
    b_sgn    = (op_in inside {3'd1, 3'd4, 3'd6}) && rs2_in[WIDTH-1];
    mag1     = a_sgn ? -rs1_in : rs1_in;
    mag2     = b_sgn ? -rs2_in : rs2_in;
    div_zero = op_in[2] && (rs2_in == '0);
    div_ovf  = (op_in == 3'd4 || op_in == 3'd6) &&
               (rs1_in == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_in == '1);
    mul_zero = !op_in[2] && ((rs1_in == '0) || (rs2_in == '0));
    spec_hit = div_zero || div_ovf || mul_zero;
    spec_res = '0;
    if (div_zero)
      spec_res = op_in[1] ? rs1_in : '1;
    else if (div_ovf)
      spec_res = op_in[1] ? '0 : rs1_in;
  end

  // One iteration of the datapath; acc holds {remainder, quotient} when dividing.
  always_comb begin
    sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    fits    = shifted >= {1'b0, b_q};
    diff    = shifted[WIDTH-1:0] - b_q;
    if (op_q[2])
      acc_d = fits ? {diff, acc_q[WIDTH-2:0], 1'b1} : {acc_q[2*WIDTH-2:0], 1'b0};
    else
      acc_d = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    prod_s = neg_q ? -acc_d : acc_d;
    quo_s  = neg_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];
    rem_s  = rneg_q ? -acc_d[2*WIDTH-1:WIDTH] : acc_d[2*WIDTH-1:WIDTH];
    case (op_q)
      3'd0:                res_d = prod_s[WIDTH-1:0];
      3'd1, 3'd2, 3'd3:    res_d = prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:          res_d = quo_s;
      default:             res_d = rem_s;
    endcase
    if (spec_q)
      res_d = spec_res_q;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      done_q     <= 1'b0;
      res_q      <= '0;
    end else if (flush_in) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (valid_in) begin
            op_q       <= op_in;
            neg_q      <= a_sgn ^ b_sgn;
            rneg_q     <= a_sgn;
            spec_q     <= spec_hit;
            spec_res_q <= spec_res;
            acc_q      <= {{WIDTH{1'b0}}, (op_in[2] ? mag1 : mag2)};
            b_q        <= op_in[2] ? mag2 : mag1;
            cnt_q      <= CW'(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
            if (spec_hit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              res_q   <= spec_res;
            end else begin
              state_q <= CALC;
            end
`else
            state_q <= CALC;
`endif
          end
        end
        CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            res_q   <= res_d;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall_out = ((state_q == IDLE) && valid_in && !flush_in) || (state_q == CALC);
  assign done_out  = done_q;
  assign res_out   = res_q;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq.
`default_nettype none

module tb_muldiv_seq;

  logic        clk_in;
  logic        rst_in;
  logic        valid_in;
  logic [2:0]  op_in;
  logic [31:0] rs1_in;
  logic [31:0] rs2_in;
  logic        flush_in;
  logic        stall_out;
  logic        done_out;
  logic [31:0] res_out;

  int n_chk = 0;
  int n_err = 0;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SP_LAT = 1;
`else
  localparam int SP_LAT = 33;
`endif

  muldiv_seq #(.WIDTH(32)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .valid_in (valid_in),
    .op_in    (op_in),
    .rs1_in   (rs1_in),
    .rs2_in   (rs2_in),
    .flush_in (flush_in),
    .stall_out(stall_out),
    .done_out (done_out),
    .res_out  (res_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one op in a cycle, then tracks stall/done until the result appears.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    int nst;
    @(negedge clk_in);
    valid_in = 1'b1;
    op_in    = op;
    rs1_in   = a;
    rs2_in   = b;
    #1 chk({tag, "_stall0"}, {31'd0, stall_out}, 32'd1);
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    lat = 1;
    nst = 0;
    while (!done_out && lat < 100) begin
      if (stall_out) nst++;
      @(posedge clk_in);
      #1 lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_nstall"}, nst, exp_lat - 1);
    chk({tag, "_res"}, res_out, exp);
    chk({tag, "_stall_done"}, {31'd0, stall_out}, 32'd0);
    @(posedge clk_in);
    #1 chk({tag, "_done_clr"}, {31'd0, done_out}, 32'd0);
  endtask

  initial begin
    rst_in   = 1'b1;
    valid_in = 1'b0;
    op_in    = 3'd0;
    rs1_in   = '0;
    rs2_in   = '0;
    flush_in = 1'b0;
    #3;
    chk("rst_done", {31'd0, done_out}, 32'd0);
    chk("rst_res", res_out, 32'd0);
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;

    do_op(3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33, "mulhsu");
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, "div");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, "rem");
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        33, "divu");
    do_op(3'd7, 32'd100,       32'd7,         32'd2,         33, "remu");
    do_op(3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, SP_LAT, "divu_dz");
    do_op(3'd6, 32'h1234,      32'd0,         32'h1234,      SP_LAT, "rem_dz");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SP_LAT, "div_ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         SP_LAT, "rem_ovf");
    do_op(3'd5, 32'd100,       32'd7,         32'd14,        33, "divu2");

    // Flush a DIV in its cycle 10; the following MUL is accepted in cycle 11.
    @(negedge clk_in);
    valid_in = 1'b1;
    op_in    = 3'd4;
    rs1_in   = 32'd100;
    rs2_in   = 32'd7;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    for (int i = 1; i < 10; i++) begin
      @(posedge clk_in);
      #1;
    end
    chk("flush_busy", {31'd0, stall_out}, 32'd1);
    @(negedge clk_in);
    flush_in = 1'b1;
    @(posedge clk_in);
    #1 flush_in = 1'b0;
    chk("flush_done", {31'd0, done_out}, 32'd0);
    chk("flush_stall", {31'd0, stall_out}, 32'd0);
    chk("flush_res", res_out, 32'd14);
    do_op(3'd0, 32'd3, 32'd4, 32'd12, 33, "mul_after_flush");

    // Asynchronous reset mid-CALC.
    @(negedge clk_in);
    valid_in = 1'b1;
    op_in    = 3'd5;
    rs1_in   = 32'd50;
    rs2_in   = 32'd3;
    @(posedge clk_in);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    chk("arst_done", {31'd0, done_out}, 32'd0);
    chk("arst_res", res_out, 32'd0);
    chk("arst_stall", {31'd0, stall_out}, 32'd0);
    @(negedge clk_in);
    rst_in = 1'b0;
    do_op(3'd7, 32'd9, 32'd4, 32'd1, 33, "remu_after_rst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

`default_nettype wire
